rr_grant_scheduler: RTL and testbench

RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

---
 rtl/rr_sched_pkg.sv | 23 ++
 rtl/rr_pick.sv | 32 +++
 rtl/rr_grant_scheduler.sv | 114 +++++++++++
 tb/tb_rr_grant_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// rr_sched_pkg -- shared definitions for the round-robin grant scheduler.
//   state_t  : FSM state encoding (IDLE=0, GRANT=1, RELEASE=2), 2 bits
//   NUM_REQ  : number of requesters (4)
//   onehot() : converts a requester index into a one-hot grant vector
package rr_sched_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin winner search.
//   req   [3:0] : request vector
//   ptr   [1:0] : index of the most recent grant holder
//   valid       : at least one request is high
//   idx   [1:0] : winner, first high request in order ptr+1, ptr+2, ptr+3, ptr
module rr_pick
  import rr_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    // Offsets 1..NUM_REQ; the last offset wraps back onto ptr itself,
    // so the previous holder has lowest priority.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler -- 4-way round-robin arbiter with a bounded hold time.
//   clock          : sole clock, rising edge
//   reset_n        : asynchronous active-low reset
//   req_0..req_3   : level-sensitive request lines
//   gnt_0..gnt_3   : registered one-hot grants
//   owner [1:0]    : index of the current holder (meaningful while busy)
//   busy           : high exactly when a grant is high
//   expired        : one-cycle pulse when a grant is cut off after MAX_HOLD cycles
// A grant lasts 1..MAX_HOLD cycles, is followed by one RELEASE cycle and one
// IDLE cycle, so the earliest re-grant is two edges after the release edge.
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_0,
  input  logic             req_1,
  input  logic             req_2,
  input  logic             req_3,
  output logic             gnt_0,
  output logic             gnt_1,
  output logic             gnt_2,
  output logic             gnt_3,
  output logic [IDX_W-1:0] owner,
  output logic             busy,
  output logic             expired
);

  localparam int unsigned    CW   = $clog2(MAX_HOLD);
  localparam logic [CW-1:0]  LAST = CW'(MAX_HOLD - 1);

  state_t             state;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [CW-1:0]      hold_cnt;
  logic [IDX_W-1:0]   ptr;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  assign req = {req_3, req_2, req_1, req_0};

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      expired  <= 1'b0;
      hold_cnt <= '0;
      ptr      <= 2'd3;
    end else begin
      expired <= 1'b0;
      case (state)
        IDLE: begin
          // Only the IDLE-cycle sample matters; requests seen while
          // granting or releasing are never stored.
          if (pick_valid) begin
            state    <= GRANT;
            gnt      <= onehot(pick_idx);
            owner    <= pick_idx;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        GRANT: begin
          // A dropped request takes precedence over the hold limit, so
          // a release on the last allowed cycle is not flagged as expired.
          if (!req[owner]) begin
            state <= RELEASE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= owner;
          end else if (hold_cnt == LAST) begin
            state   <= RELEASE;
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= owner;
            expired <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_0 = gnt[0];
  assign gnt_1 = gnt[1];
  assign gnt_2 = gnt[2];
  assign gnt_3 = gnt[3];

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb_rr_grant_scheduler -- directed, table-driven bench for rr_grant_scheduler
// (MAX_HOLD = 8), plus hand-written sequences for hold expiry, a release on
// the last allowed cycle and asynchronous reset during a grant.
module tb_rr_grant_scheduler;

  logic       clock;
  logic       reset_n;
  logic       req_0, req_1, req_2, req_3;
  logic       gnt_0, gnt_1, gnt_2, gnt_3;
  logic [1:0] owner;
  logic       busy;
  logic       expired;

  int errors = 0;
  int checks = 0;

  rr_grant_scheduler #(.MAX_HOLD(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req_0   (req_0),
    .req_1   (req_1),
    .req_2   (req_2),
    .req_3   (req_3),
    .gnt_0   (gnt_0),
    .gnt_1   (gnt_1),
    .gnt_2   (gnt_2),
    .gnt_3   (gnt_3),
    .owner   (owner),
    .busy    (busy),
    .expired (expired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       expired;
  } vec_t;

  vec_t vecs[22];

  task automatic set_req(input logic [3:0] r);
    {req_3, req_2, req_1, req_0} = r;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // owner is only compared while a grant is expected.
  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eo,
                       input logic eb, input logic ee);
    logic [3:0] g;
    g = {gnt_3, gnt_2, gnt_1, gnt_0};
    checks++;
    if (g !== eg || busy !== eb || expired !== ee || (eb && owner !== eo)) begin
      errors++;
      $display("FAIL %s: got gnt=%b owner=%0d busy=%b expired=%b, want gnt=%b owner=%0d busy=%b expired=%b",
               name, g, owner, busy, expired, eg, eo, eb, ee);
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    set_req(4'b0000);
    #1 check("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    if (owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_owner: got %0d want 0", owner);
    end
    checks++;
    step();
    #4 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // {req, gnt, owner, busy, expired}; ptr starts at 3 after reset
    vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // idle stays idle
    vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0}; // req_2 alone -> gnt_2 at once
    vecs[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0}; // drop -> RELEASE, ptr=2
    vecs[4]  = '{4'b0010, 4'b0000, 2'd2, 1'b0, 1'b0}; // RELEASE -> IDLE, req ignored
    vecs[5]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0}; // gnt_1 cycle 1
    vecs[6]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0}; // cycle 2
    vecs[7]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0}; // cycle 3
    vecs[8]  = '{4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0}; // release, no expiry, ptr=1
    vecs[9]  = '{4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0}; // RELEASE -> IDLE
    vecs[10] = '{4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0}; // ptr=1 -> 2 wins
    vecs[11] = '{4'b0001, 4'b0000, 2'd2, 1'b0, 1'b0}; // owner 2 drops, ptr=2
    vecs[12] = '{4'b1011, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[13] = '{4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0}; // ptr=2 -> 3 wins over 0,1
    vecs[14] = '{4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0}; // ptr=3
    vecs[15] = '{4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[16] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0}; // gnt_0
    vecs[17] = '{4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0}; // req_3 pulse ignored
    vecs[18] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[19] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // release
    vecs[20] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // IDLE, no stale grant to 3
    vecs[21] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    reset_n = 1'b0;
    set_req(4'b0000);
    #1 check("reset_initial", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    #4 reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      set_req(vecs[i].req);
      step();
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].owner, vecs[i].busy, vecs[i].expired);
    end

    // All requesters held high: 0,1,2,3,0, each 8 cycles then an expiry.
    do_reset();
    set_req(4'b1111);
    begin
      logic [1:0] w;
      w = 2'd0;
      for (int n = 0; n < 5; n++) begin
        for (int c = 0; c < 8; c++) begin
          step();
          check($sformatf("all_g%0d_c%0d", n, c), 4'b0001 << w, w, 1'b1, 1'b0);
        end
        step();
        check($sformatf("all_g%0d_expire", n), 4'b0000, w, 1'b0, 1'b1);
        step();
        check($sformatf("all_g%0d_idle", n), 4'b0000, w, 1'b0, 1'b0);
        w = w + 2'd1;
      end
    end

    // req_3 drops exactly when hold_cnt reaches 7: normal release.
    do_reset();
    set_req(4'b1000);
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("last_c%0d", c), 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    set_req(4'b0000);
    step();
    check("last_release", 4'b0000, 2'd3, 1'b0, 1'b0);
    step();
    check("last_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant.
    set_req(4'b0010);
    step();
    check("async_pre", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 check("async_clear", 4'b0000, 2'd0, 1'b0, 1'b0);
    set_req(4'b0011);
    #3 reset_n = 1'b1;
    step();
    check("async_first_arb", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
